// File: rtl/uart_tx_fifo_if.sv
// Bus bundle between the SoC write path / uart transmitter and uart_tx_fifo.
// Handshakes:
//   write side : a byte is accepted on a rising clk edge when wr_en && wr_ready;
//                wr_en while !wr_ready drops the byte and raises overflow.
//   uart side  : uart_send is a one-cycle request carrying uart_data; the uart
//                acknowledges by dropping uart_ready, and returns it high when idle.
interface uart_tx_fifo_if #(
   parameter int DEPTH = 16
) ();
   localparam int PTR_BITS = $clog2(DEPTH);

   logic                wr_en;
   logic [7:0]          wr_data;
   logic                wr_ready;
   logic                clr_overflow;
   logic [7:0]          uart_data;
   logic                uart_send;
   logic                uart_ready;
   logic [PTR_BITS:0]   level;
   logic                empty;
   logic                full;
   logic                overflow;

   // SoC plus uart environment side
   modport master (
      output wr_en, wr_data, clr_overflow, uart_ready,
      input  wr_ready, uart_data, uart_send, level, empty, full, overflow
   );

   // FIFO side
   modport slave (
      input  wr_en, wr_data, clr_overflow, uart_ready,
      output wr_ready, uart_data, uart_send, level, empty, full, overflow
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a uart transmitter through its sendReq/ready handshake.
// Keeps a separate level counter (full/empty come only from it), a sticky
// overflow flag for dropped pushes, and a small IDLE/SENT/BUSY drain FSM.
// dbg_state encoding: 0 = IDLE, 1 = SENT, 2 = BUSY.
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   localparam int PTR_BITS = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              resetn,
   uart_tx_fifo_if.slave     bus,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SENT = 2'd1,
      ST_BUSY = 2'd2
   } state_t;

   localparam logic [PTR_BITS:0]   LEVEL_FULL = (PTR_BITS+1)'(DEPTH);
   localparam logic [PTR_BITS:0]   LEVEL_ONE  = (PTR_BITS+1)'(1);
   localparam logic [PTR_BITS-1:0] PTR_ONE    = PTR_BITS'(1);

   state_t              state_q, state_d;
   logic [7:0]          mem_q [DEPTH];
   logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_BITS:0]   level_q, level_d;
   logic                overflow_q, overflow_d;
   logic                uart_send_q, uart_send_d;
   logic [7:0]          uart_data_q, uart_data_d;

   logic full, empty, push, drop, pop;

   assign full  = (level_q == LEVEL_FULL);
   assign empty = (level_q == '0);
   // A push into a full FIFO is dropped even if a pop frees a slot at the same edge.
   assign push  = bus.wr_en && !full;
   assign drop  = bus.wr_en && full;

   // Storage write; contents need no reset since level gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.wr_data;
      end
   end

   // Pointer, level and overflow next-state; pop and push together keep level.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
         level_d = level_q + LEVEL_ONE;
      end else if (pop && !push) begin
         level_d = level_q - LEVEL_ONE;
      end
      // Setting wins over clearing when both happen in one cycle.
      if (drop) begin
         overflow_d = 1'b1;
      end else if (bus.clr_overflow) begin
         overflow_d = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: SENT waits for the uart to take the byte, BUSY for it to finish.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (pop)             state_d = ST_SENT;
         ST_SENT: if (!bus.uart_ready) state_d = ST_BUSY;
         ST_BUSY: if (bus.uart_ready)  state_d = ST_IDLE;
         default:                      state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: pop and launch a one-cycle send only from IDLE with the uart idle.
   always_comb begin
      pop         = 1'b0;
      uart_send_d = 1'b0;
      uart_data_d = uart_data_q;
      if (state_q == ST_IDLE && !empty && bus.uart_ready) begin
         pop         = 1'b1;
         uart_send_d = 1'b1;
         uart_data_d = mem_q[rd_ptr_q];
      end
   end

   // Datapath and output registers; reset aborts any in-flight send.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         uart_send_q <= 1'b0;
         uart_data_q <= 8'h00;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         uart_send_q <= uart_send_d;
         uart_data_q <= uart_data_d;
      end
   end

   assign bus.wr_ready  = !full;
   assign bus.uart_data = uart_data_q;
   assign bus.uart_send = uart_send_q;
   assign bus.level     = level_q;
   assign bus.empty     = empty;
   assign bus.full      = full;
   assign bus.overflow  = overflow_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model, uart
// responder, per-cycle monitor, table-driven fill vectors and hand sequences.
module tb_uart_tx_fifo;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [1:0] dbg_state;

   uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

   uart_tx_fifo #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int         errors = 0;
   int         checks = 0;
   int         sent_cnt = 0;
   int         busy_len = 10;
   bit         force_busy = 1'b0;
   bit         m_ovf = 1'b0;
   logic [7:0] exp_q[$];

   logic [1:0] prev_state;
   logic       prev_ready, prev_send;
   bit         prev_ok = 1'b0;

   typedef struct {
      int         n_push;
      logic [4:0] exp_level;
      logic       exp_full;
      logic       exp_empty;
      logic       exp_ovf;
      int         exp_sent;
   } vec_t;
   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // All bench driving and sampling happens 2 time units after the rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      resetn           = 1'b0;
      bus.wr_en        = 1'b0;
      bus.wr_data      = 8'h00;
      bus.clr_overflow = 1'b0;
      exp_q.delete();
      m_ovf = 1'b0;
      repeat (3) tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic push_byte(input logic [7:0] b);
      bus.wr_en   = 1'b1;
      bus.wr_data = b;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (!(exp_q.size() == 0 && bus.level == 0 && dbg_state == 2'd0 && bus.uart_ready)
             && n < 3000) begin
         tick();
         n++;
      end
      chk({name, "_drain_done"}, 32'(n < 3000), 32'd1);
   endtask

   // Reference model: a plain queue of accepted bytes, capacity DEPTH.
   always @(posedge clk) begin
      bit drop_now;
      if (resetn) begin
         drop_now = bus.wr_en && (exp_q.size() >= DEPTH);
         if (drop_now) m_ovf = 1'b1;
         else if (bus.clr_overflow) m_ovf = 1'b0;
         if (bus.wr_en && !drop_now) exp_q.push_back(bus.wr_data);
      end
   end

   // Uart responder: takes each pulse, stays busy busy_len cycles.
   initial begin
      int busy_cnt = 0;
      bus.uart_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (resetn && bus.uart_send) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_send: actual=0x%0h required=none", bus.uart_data);
            end else begin
               chk("uart_data_order", 32'(bus.uart_data), 32'(exp_q.pop_front()));
            end
            sent_cnt++;
            bus.uart_ready = 1'b0;
            busy_cnt = busy_len;
         end else if (force_busy) begin
            bus.uart_ready = 1'b0;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) bus.uart_ready = 1'b1;
         end else begin
            bus.uart_ready = 1'b1;
         end
      end
   end

   // Per-cycle monitor: status against the model plus handshake properties.
   always @(negedge clk) begin
      if (!resetn) begin
         prev_ok = 1'b0;
      end else begin
         chk("mon_level",    32'(bus.level),    32'(exp_q.size()));
         chk("mon_full",     32'(bus.full),     32'(exp_q.size() == DEPTH));
         chk("mon_empty",    32'(bus.empty),    32'(exp_q.size() == 0));
         chk("mon_wr_ready", 32'(bus.wr_ready), 32'(exp_q.size() != DEPTH));
         chk("mon_overflow", 32'(bus.overflow), 32'(m_ovf));
         chk("mon_level_max", 32'(bus.level > DEPTH), 32'd0);
         if (prev_ok && bus.uart_send) begin
            chk("mon_send_origin", 32'({prev_state, prev_ready, prev_send}),
                32'({2'd0, 1'b1, 1'b0}));
         end
         prev_ok    = 1'b1;
         prev_state = dbg_state;
         prev_ready = bus.uart_ready;
         prev_send  = bus.uart_send;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int n;

      vecs[0] = '{n_push: 0,  exp_level: 5'd0,  exp_full: 1'b0, exp_empty: 1'b1, exp_ovf: 1'b0, exp_sent: 0};
      vecs[1] = '{n_push: 1,  exp_level: 5'd1,  exp_full: 1'b0, exp_empty: 1'b0, exp_ovf: 1'b0, exp_sent: 1};
      vecs[2] = '{n_push: 5,  exp_level: 5'd5,  exp_full: 1'b0, exp_empty: 1'b0, exp_ovf: 1'b0, exp_sent: 5};
      vecs[3] = '{n_push: 15, exp_level: 5'd15, exp_full: 1'b0, exp_empty: 1'b0, exp_ovf: 1'b0, exp_sent: 15};
      vecs[4] = '{n_push: 16, exp_level: 5'd16, exp_full: 1'b1, exp_empty: 1'b0, exp_ovf: 1'b0, exp_sent: 16};
      vecs[5] = '{n_push: 17, exp_level: 5'd16, exp_full: 1'b1, exp_empty: 1'b0, exp_ovf: 1'b1, exp_sent: 16};
      vecs[6] = '{n_push: 20, exp_level: 5'd16, exp_full: 1'b1, exp_empty: 1'b0, exp_ovf: 1'b1, exp_sent: 16};

      // Reset state
      do_reset();
      chk("rst_level",     32'(bus.level),     32'd0);
      chk("rst_empty",     32'(bus.empty),     32'd1);
      chk("rst_full",      32'(bus.full),      32'd0);
      chk("rst_wr_ready",  32'(bus.wr_ready),  32'd1);
      chk("rst_overflow",  32'(bus.overflow),  32'd0);
      chk("rst_uart_send", 32'(bus.uart_send), 32'd0);
      chk("rst_uart_data", 32'(bus.uart_data), 32'd0);
      chk("rst_state",     32'(dbg_state),     32'd0);

      // Two bytes, uart busy 10 cycles per byte; first pulse two cycles after push
      busy_len = 10;
      base = sent_cnt;
      bus.wr_en = 1'b1;
      bus.wr_data = 8'h48;
      tick();
      chk("hi_send_early", 32'(bus.uart_send), 32'd0);
      chk("hi_level_1",    32'(bus.level),     32'd1);
      bus.wr_data = 8'h69;
      tick();
      bus.wr_en = 1'b0;
      chk("hi_send_first", 32'(bus.uart_send), 32'd1);
      chk("hi_data_first", 32'(bus.uart_data), 32'h48);
      chk("hi_level_pp",   32'(bus.level),     32'd1);
      tick();
      chk("hi_pulse_len",  32'(bus.uart_send), 32'd0);
      chk("hi_data_hold",  32'(bus.uart_data), 32'h48);
      drain("hi");
      chk("hi_sent",  32'(sent_cnt - base), 32'd2);
      chk("hi_empty", 32'(bus.empty),       32'd1);
      chk("hi_level", 32'(bus.level),       32'd0);

      // Fill vectors with the uart held busy, then drain
      for (int i = 0; i < 7; i++) begin
         force_busy = 1'b1;
         do_reset();
         base = sent_cnt;
         for (int k = 0; k < vecs[i].n_push; k++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(k);
            tick();
         end
         bus.wr_en = 1'b0;
         tick();
         chk("tbl_level",    32'(bus.level),    32'(vecs[i].exp_level));
         chk("tbl_full",     32'(bus.full),     32'(vecs[i].exp_full));
         chk("tbl_empty",    32'(bus.empty),    32'(vecs[i].exp_empty));
         chk("tbl_wr_ready", 32'(bus.wr_ready), 32'(!vecs[i].exp_full));
         chk("tbl_overflow", 32'(bus.overflow), 32'(vecs[i].exp_ovf));
         force_busy = 1'b0;
         drain("tbl");
         chk("tbl_sent", 32'(sent_cnt - base), 32'(vecs[i].exp_sent));
      end

      // Dropped push and clr_overflow in the same cycle: set wins
      force_busy = 1'b1;
      do_reset();
      base = sent_cnt;
      for (int k = 0; k < DEPTH; k++) push_byte(8'(8'h80 + k));
      bus.wr_en = 1'b1;
      bus.wr_data = 8'h77;
      bus.clr_overflow = 1'b1;
      tick();
      bus.wr_en = 1'b0;
      chk("clr_set_wins", 32'(bus.overflow), 32'd1);
      chk("clr_level",    32'(bus.level),    32'd16);
      tick();
      bus.clr_overflow = 1'b0;
      chk("clr_alone", 32'(bus.overflow), 32'd0);
      force_busy = 1'b0;
      drain("clr");
      chk("clr_sent", 32'(sent_cnt - base), 32'd16);

      // Simultaneous push and pop at level 3
      force_busy = 1'b1;
      do_reset();
      base = sent_cnt;
      for (int k = 0; k < 3; k++) push_byte(8'(8'h31 + k));
      tick();
      chk("pp_level_pre", 32'(bus.level), 32'd3);
      force_busy = 1'b0;
      tick();
      bus.wr_en = 1'b1;
      bus.wr_data = 8'h34;
      tick();
      bus.wr_en = 1'b0;
      chk("pp_send",  32'(bus.uart_send), 32'd1);
      chk("pp_data",  32'(bus.uart_data), 32'h31);
      chk("pp_level", 32'(bus.level),     32'd3);
      drain("pp");
      chk("pp_sent", 32'(sent_cnt - base), 32'd4);

      // Reset while a send pulse is active with level 5
      busy_len = 10;
      force_busy = 1'b1;
      do_reset();
      for (int k = 0; k < 6; k++) push_byte(8'(8'hA0 + k));
      force_busy = 1'b0;
      n = 0;
      while (!bus.uart_send && n < 20) begin
         tick();
         n++;
      end
      chk("rm_pulse_seen", 32'(bus.uart_send), 32'd1);
      chk("rm_level_5",    32'(bus.level),     32'd5);
      chk("rm_data",       32'(bus.uart_data), 32'hA0);
      #1;
      resetn = 1'b0;
      exp_q.delete();
      m_ovf = 1'b0;
      #1;
      chk("rm_send_abort", 32'(bus.uart_send), 32'd0);
      chk("rm_level_0",    32'(bus.level),     32'd0);
      chk("rm_empty",      32'(bus.empty),     32'd1);
      tick();
      tick();
      resetn = 1'b1;
      tick();
      chk("rm_state_idle", 32'(dbg_state), 32'd0);
      base = sent_cnt;
      push_byte(8'h55);
      drain("rm");
      chk("rm_sent", 32'(sent_cnt - base), 32'd1);

      // Random pacing below drain rate, across pointer wrap
      busy_len = 3;
      base = sent_cnt;
      for (int k = 0; k < 40; k++) begin
         push_byte(8'($urandom));
         repeat ($urandom_range(8, 14)) tick();
      end
      drain("rnd");
      chk("rnd_sent",     32'(sent_cnt - base), 32'd40);
      chk("rnd_overflow", 32'(bus.overflow),    32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
